// File: rtl/miso_pack_fifo.sv
// Circular multi-input single-output FIFO between the router and the PE array.
// Compacts valid write lanes and pops 1/2/4 packed entries per word, with a mark/rewind replay window.
module miso_pack_fifo #(
  parameter int DEPTH       = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_LENGTH = 8,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                                    i_clk,
  input  logic                                    i_nrst,
  input  logic                                    i_clear,
  input  logic                                    i_write_en,
  input  logic [DATA_LENGTH-1:0]                  i_valid,
  input  logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0]  i_data,
  output logic                                    o_w_ready,
  input  logic                                    i_pop_en,
  input  logic [1:0]                              i_p_mode,
  input  logic                                    i_retain,
  input  logic                                    i_rewind,
  output logic [DATA_WIDTH-1:0]                   o_data,
  output logic                                    o_pop_valid,
  output logic [2:0]                              o_pop_num,
  output logic [CNT_WIDTH-1:0]                    o_count,
  output logic                                    o_empty,
  output logic                                    o_full
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int HW = DATA_WIDTH / 2;
  localparam int QW = DATA_WIDTH / 4;

  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  typedef enum logic [1:0] {
    MODE_8B   = 2'b00,
    MODE_4B   = 2'b01,
    MODE_2B   = 2'b10,
    MODE_RSVD = 2'b11
  } p_mode_e;

  p_mode_e mode;
  assign mode = p_mode_e'(i_p_mode);

  ptr_t w_ptr_q, w_ptr_d;
  ptr_t r_ptr_q, r_ptr_d;
  ptr_t m_ptr_q, m_ptr_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] pop_data_q, pop_data;
  logic                  pop_valid_q;
  logic [2:0]            pop_num_q, pop_n;

  ptr_t                  unread, used, free_slots, n_valid, per_word;
  ptr_t                  lane_off [DATA_LENGTH];
  logic [ADDR_WIDTH-1:0] wr_idx   [DATA_LENGTH];
  logic [ADDR_WIDTH-1:0] rd_idx   [4];
  logic                  wr_fire, pop_fire;

  // Lane compaction: each valid lane lands at w_ptr plus the number of valid lanes below it.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      lane_off[i] = n_valid;
      wr_idx[i]   = ADDR_WIDTH'(w_ptr_q + n_valid);
      n_valid     = n_valid + ptr_t'(i_valid[i]);
    end
  end

  // Free space is measured from the mark, so retained entries are never overwritten.
  assign unread     = w_ptr_q - r_ptr_q;
  assign used       = w_ptr_q - m_ptr_q;
  assign free_slots = DEPTH_P - used;

  assign o_w_ready = (n_valid <= free_slots);
  assign o_count   = CNT_WIDTH'(unread);
  assign o_empty   = (unread == '0);
  assign o_full    = (used == DEPTH_P);

  assign wr_fire  = i_write_en & o_w_ready & ~i_clear;
  assign pop_fire = i_pop_en & ~o_empty & ~i_rewind & ~i_clear & (mode != MODE_RSVD);

  // NOTE: every signal written in this block gets a default first, so no latch is inferred.
  always_comb begin
    pop_data = '0;
    unique case (mode)
      MODE_4B: per_word = ptr_t'(2);
      MODE_2B: per_word = ptr_t'(4);
      default: per_word = ptr_t'(1);
    endcase
    pop_n = (unread < per_word) ? 3'(unread) : 3'(per_word);
    for (int j = 0; j < 4; j++) begin
      rd_idx[j] = ADDR_WIDTH'(r_ptr_q + ptr_t'(j));
    end
    // Pack LSB-first; slices beyond the available entries stay zero.
    unique case (mode)
      MODE_8B: pop_data = mem_q[rd_idx[0]];
      MODE_4B: begin
        for (int j = 0; j < 2; j++) begin
          if (3'(j) < pop_n) pop_data[j*HW +: HW] = mem_q[rd_idx[j]][HW-1:0];
        end
      end
      MODE_2B: begin
        for (int j = 0; j < 4; j++) begin
          if (3'(j) < pop_n) pop_data[j*QW +: QW] = mem_q[rd_idx[j]][QW-1:0];
        end
      end
      default: pop_data = '0;
    endcase
  end

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    m_ptr_d = m_ptr_q;
    if (i_clear) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      m_ptr_d = '0;
    end else begin
      if (wr_fire) w_ptr_d = w_ptr_q + n_valid;
      if (i_rewind)      r_ptr_d = m_ptr_q;
      else if (pop_fire) r_ptr_d = r_ptr_q + ptr_t'(pop_n);
      // Without retain the mark trails the read pointer, releasing popped slots at once.
      if (!i_retain) m_ptr_d = r_ptr_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      m_ptr_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      pop_num_q   <= '0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      m_ptr_q     <= m_ptr_d;
      pop_data_q  <= pop_fire ? pop_data : '0;
      pop_valid_q <= pop_fire;
      pop_num_q   <= pop_fire ? pop_n : 3'd0;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      for (int i = 0; i < DATA_LENGTH; i++) begin
        if (i_valid[i]) mem_q[wr_idx[i]] <= i_data[i];
      end
    end
  end

  assign o_data      = pop_data_q;
  assign o_pop_valid = pop_valid_q;
  assign o_pop_num   = pop_num_q;

endmodule

// File: tb/tb_miso_pack_fifo.sv
// Self-checking bench for miso_pack_fifo: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model of the replay window.
module tb_miso_pack_fifo;

  localparam int DEPTH = 32;
  localparam int DW    = 8;
  localparam int DL    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                    i_clk = 1'b0;
  logic                    i_nrst = 1'b0;
  logic                    i_clear = 1'b0;
  logic                    i_write_en = 1'b0;
  logic [DL-1:0]           i_valid = '0;
  logic [DL-1:0][DW-1:0]   i_data = '0;
  logic                    o_w_ready;
  logic                    i_pop_en = 1'b0;
  logic [1:0]              i_p_mode = 2'b00;
  logic                    i_retain = 1'b0;
  logic                    i_rewind = 1'b0;
  logic [DW-1:0]           o_data;
  logic                    o_pop_valid;
  logic [2:0]              o_pop_num;
  logic [CW-1:0]           o_count;
  logic                    o_empty;
  logic                    o_full;

  miso_pack_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .DATA_LENGTH(DL)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_clear(i_clear), .i_write_en(i_write_en),
    .i_valid(i_valid), .i_data(i_data), .o_w_ready(o_w_ready), .i_pop_en(i_pop_en),
    .i_p_mode(i_p_mode), .i_retain(i_retain), .i_rewind(i_rewind), .o_data(o_data),
    .o_pop_valid(o_pop_valid), .o_pop_num(o_pop_num), .o_count(o_count),
    .o_empty(o_empty), .o_full(o_full)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mq holds every entry from the mark onward; rd_off counts those already read.
  logic [DW-1:0] mq[$];
  int            rd_off = 0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_valid = 1'b0;
  logic [2:0]    exp_num = '0;
  bit            chk_en = 1'b0;
  int            m_unread, m_per, m_n, m_sw;
  bit            m_ready;
  logic [31:0]   m_acc;

  always @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst || i_clear) begin
      mq.delete();
      rd_off    = 0;
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_num   = '0;
    end else begin
      m_unread  = mq.size() - rd_off;
      m_ready   = ($countones(i_valid) <= DEPTH - mq.size());
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_num   = '0;
      if (i_pop_en && m_unread > 0 && !i_rewind && i_p_mode != 2'b11) begin
        m_per = 1 << i_p_mode;
        m_n   = (m_unread < m_per) ? m_unread : m_per;
        m_sw  = DW / m_per;
        m_acc = '0;
        for (int j = 0; j < m_n; j++)
          m_acc |= ((32'(mq[rd_off + j])) & ((32'd1 << m_sw) - 1)) << (j * m_sw);
        exp_data  = m_acc[DW-1:0];
        exp_valid = 1'b1;
        exp_num   = 3'(m_n);
        rd_off   += m_n;
      end
      if (i_rewind) rd_off = 0;
      if (i_write_en && m_ready)
        for (int i = 0; i < DL; i++) if (i_valid[i]) mq.push_back(i_data[i]);
      if (!i_retain) begin
        repeat (rd_off) void'(mq.pop_front());
        rd_off = 0;
      end
    end
  end

  int c_used;
  always @(negedge i_clk) begin
    if (chk_en && i_nrst) begin
      c_used = mq.size();
      check("pop_valid", o_pop_valid, exp_valid);
      check("pop_num", o_pop_num, exp_num);
      check("data", o_data, exp_data);
      check("count", o_count, c_used - rd_off);
      check("empty", o_empty, (c_used - rd_off) == 0);
      check("full", o_full, c_used == DEPTH);
      check("w_ready", o_w_ready, $countones(i_valid) <= DEPTH - c_used);
    end
  end

  // Applies one cycle of inputs (called at posedge+2), returns at the next posedge+2 with inputs idle.
  task automatic cyc(input logic we, input logic [DL-1:0] val, input logic [DL*DW-1:0] dat,
                     input logic pop, input logic [1:0] mode, input logic rew, input logic clr);
    i_write_en = we; i_valid = val; i_data = dat; i_pop_en = pop;
    i_p_mode = mode; i_rewind = rew; i_clear = clr;
    @(posedge i_clk); #2;
    i_write_en = 1'b0; i_valid = '0; i_pop_en = 1'b0; i_rewind = 1'b0; i_clear = 1'b0;
  endtask

  function automatic logic [DL*DW-1:0] lanes(input int base);
    logic [DL*DW-1:0] r;
    for (int i = 0; i < DL; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  task automatic wr(input logic [DL-1:0] val, input logic [DL*DW-1:0] dat);
    cyc(1'b1, val, dat, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic pop_chk(input string name, input logic [1:0] mode, input int d, input int n);
    cyc(1'b0, '0, '0, 1'b1, mode, 1'b0, 1'b0);
    check({name, "_data"}, o_data, d);
    check({name, "_num"}, o_pop_num, n);
  endtask

  logic [DL*DW-1:0] dv;
  initial begin
    repeat (3) @(posedge i_clk);
    #2;
    check("rst_data", o_data, 0);
    check("rst_valid", o_pop_valid, 0);
    check("rst_num", o_pop_num, 0);
    check("rst_count", o_count, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    i_nrst = 1'b1;
    chk_en = 1'b1;

    // Lane compaction
    wr(8'b1010_0101, lanes(1));
    check("compact_count", o_count, 4);
    pop_chk("compact0", 2'b00, 1, 1);
    pop_chk("compact1", 2'b00, 3, 1);
    pop_chk("compact2", 2'b00, 6, 1);
    pop_chk("compact3", 2'b00, 8, 1);
    check("compact_empty", o_empty, 1);

    // 4b mode, odd count
    dv = '0; dv[7:0] = 8'hA1; dv[15:8] = 8'hB2; dv[23:16] = 8'hC3;
    wr(8'h07, dv);
    pop_chk("p4b0", 2'b01, 'h21, 2);
    pop_chk("p4b1", 2'b01, 'h03, 1);
    check("p4b_empty", o_empty, 1);

    // 2b mode
    dv = '0; dv[7:0] = 8'h01; dv[15:8] = 8'h02; dv[23:16] = 8'h03; dv[31:24] = 8'h00; dv[39:32] = 8'h01;
    wr(8'h1F, dv);
    pop_chk("p2b0", 2'b10, 'h39, 4);
    pop_chk("p2b1", 2'b10, 'h01, 1);

    // Wrap and full
    for (int b = 0; b < 4; b++) wr(8'hFF, lanes(8'h10 + 8 * b));
    check("wrap_full", o_full, 1);
    check("wrap_count32", o_count, 32);
    i_valid = 8'hFF;
    #1 check("wrap_wready", o_w_ready, 0);
    #1;
    wr(8'hFF, lanes(8'h90));
    check("wrap_drop_count", o_count, 32);
    for (int k = 0; k < 8; k++) pop_chk("wrap_pop", 2'b00, 8'h10 + k, 1);
    wr(8'hFF, lanes(8'h40));
    check("wrap_refill_count", o_count, 32);
    for (int k = 0; k < 24; k++) pop_chk("wrap_order", 2'b00, 8'h18 + k, 1);
    for (int k = 0; k < 8; k++) pop_chk("wrap_tail", 2'b00, 8'h40 + k, 1);
    check("wrap_empty", o_empty, 1);

    // Retain / rewind, with a pop colliding with the rewind
    i_retain = 1'b1;
    wr(8'hFF, lanes(8'h60));
    for (int k = 0; k < 8; k++) pop_chk("ret_pop", 2'b00, 8'h60 + k, 1);
    check("ret_empty", o_empty, 1);
    cyc(1'b0, '0, '0, 1'b1, 2'b00, 1'b1, 1'b0);
    check("rew_pop_valid", o_pop_valid, 0);
    check("rew_count", o_count, 8);
    for (int k = 0; k < 8; k++) pop_chk("replay", 2'b00, 8'h60 + k, 1);
    for (int b = 0; b < 3; b++) wr(8'hFF, lanes(8'h70 + 8 * b));
    check("ret_full", o_full, 1);
    for (int k = 0; k < 24; k++) pop_chk("ret_drain", 2'b00, 8'h70 + k, 1);
    check("ret_full_unread0", o_full, 1);
    check("ret_count0", o_count, 0);
    i_retain = 1'b0;
    cyc(1'b0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0);
    check("release_full", o_full, 0);

    // Clear + write in the same cycle
    wr(8'hFF, lanes(8'h11));
    cyc(1'b1, 8'hFF, lanes(8'h22), 1'b0, 2'b00, 1'b0, 1'b1);
    check("clear_count", o_count, 0);
    check("clear_empty", o_empty, 1);

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) i_retain = ($urandom_range(0, 2) == 0);
      cyc($urandom_range(0, 3) != 0, DL'($urandom), {$urandom, $urandom},
          $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end
    i_retain = 1'b0;
    cyc(1'b0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b1);

    // Asynchronous reset mid-stream
    wr(8'hFF, lanes(8'h33));
    pop_chk("pre_rst", 2'b00, 8'h33, 1);
    check("pre_rst_valid", o_pop_valid, 1);
    i_pop_en = 1'b1;
    i_nrst = 1'b0;
    #1;
    check("arst_valid", o_pop_valid, 0);
    check("arst_data", o_data, 0);
    check("arst_num", o_pop_num, 0);
    check("arst_count", o_count, 0);
    @(posedge i_clk); #2;
    i_pop_en = 1'b0;
    i_nrst = 1'b1;
    repeat (2) cyc(1'b0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0);
    check("post_rst_empty", o_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
